branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the pipelined RV64 core. It replaces the current "always predict fall-through, resolve in MEM" policy. It holds a table of saturating direction counters indexed by PC and, optionally, a branch target buffer. Fetch queries it combinationally with the current PC. The stage that resolves branches trains it one cycle per resolved branch. It also keeps saturating performance counters for branches and mispredictions.

## Interface
- `ENTRIES`, default 64: number of table entries; power of two, at least 4; `IDX_W = log2(ENTRIES)`.
- `CTR_W`, default 2: direction counter width, 1 to 4 bits.
- `PC_W`, default 64: PC width.
- `STAT_W`, default 32: width of the performance counters.
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `lookup_pc`  in  PC_W: PC of the instruction being fetched.
- `pred_taken`  out  1: prediction that the branch is taken.
- `pred_hit`  out  1: BTB tag match (0 when the BTB is compiled out).
- `pred_target`  out  PC_W: predicted next PC.
- `update_valid`  in  1: a resolved branch is presented this cycle.
- `update_pc`  in  PC_W: PC of the resolved branch.
- `update_taken`  in  1: actual branch outcome.
- `update_target`  in  PC_W: actual taken target.
- `update_mispredict`  in  1: the pipeline flushed for this branch; qualified by `update_valid`.
- `stat_branches`  out  STAT_W: count of resolved branches.
- `stat_mispredicts`  out  STAT_W: count of mispredicted branches.

## Operation
- **Index:** `idx = pc[IDX_W+1:2]`. PC bits [1:0] are ignored.
- **Lookup:** read `ctr[idx(lookup_pc)]`. The prediction is taken when the counter MSB is 1.
- **Update on `update_valid`:**
  - If `update_taken`, `ctr[idx(update_pc)]` increments and saturates at `2^CTR_W - 1`.
  - Otherwise it decrements and saturates at 0.
  - No tag check is made on counters; aliasing is allowed.
- **Performance counters:**
  - `stat_branches` increments on each `update_valid`.
  - `stat_mispredicts` increments when `update_valid & update_mispredict`.
  - Both saturate at all-ones and never wrap.
- **Without the BTB (see Configuration):** `pred_hit=0` and `pred_target = lookup_pc + 4` always. `pred_taken` is the direction only; decode computes the target itself.
- **Reset:** every counter is set to weakly-not-taken, `2^(CTR_W-1) - 1` (01 for CTR_W=2; 0 for CTR_W=1). All BTB valid bits clear. Both stats go to 0.
- **Reset outputs, with `lookup_pc` held:** `pred_taken=0`, `pred_hit=0`, `pred_target = lookup_pc + 4`.
- **`reset` during an update:** reset wins and the update is dropped.

## Timing
- Lookup is zero-latency: outputs are combinational from `lookup_pc` and the table registers.
- An update becomes visible to lookup on the cycle after the edge that samples it.
- **Same index looked up and updated in one cycle:** lookup returns the old counter (read-before-write) and the new value appears the next cycle.
- One update per cycle, with no back-pressure. `update_*` is ignored when `update_valid=0`.
- **Arithmetic:** `lookup_pc + 4` wraps modulo 2^PC_W.

## Configuration
- Macro: `BRANCH_PREDICTOR_BTB_EN`.
- **Defined:**
  - Each entry also stores a valid bit, `tag = pc[PC_W-1:IDX_W+2]` and a PC_W target.
  - `pred_hit` = valid & tag match.
  - `pred_taken = pred_hit & ctr_msb`.
  - `pred_target` is the stored target when `pred_taken`, otherwise `lookup_pc + 4`.
  - On an update with `update_taken`, the entry is written with valid, tag and `update_target`; this replaces any aliasing entry.
  - On a not-taken update, valid, tag and target are unchanged.
- **Undefined:** no BTB storage; behaviour is as stated under Operation.

## Structure
- Package `bp_pkg` holds:
  - function `bp_idx(pc)`;
  - function `ctr_init(CTR_W)`;
  - saturating inc/dec functions;
  - the default-parameter constants.
- Sub-module `sat_counter` (width-parametrised up/down saturating counter with synchronous load):
  - instantiated twice for the stats counters;
  - its functions are reused for the table entries.
- The table is a register array. It is not inferred as RAM, because the read must be combinational and reset must clear every entry in one cycle.

## Test plan
- **Reset state:** after reset, lookup at 0x100 gives `pred_taken=0`, `pred_hit=0`, `pred_target=0x104`, and both stats are 0.
- **Direction training:** two taken updates at PC 0x100 make `pred_taken=1`. A third leaves the counter saturated at 3. Two not-taken updates return `pred_taken=0`.
- **Aliasing:** with ENTRIES=64, PC 0x100 and 0x200 share index 0. A taken update at 0x200 is visible at 0x100 through the counter. With the BTB enabled, `pred_hit=0` at 0x100 because the tag differs.
- **BTB:** with `BRANCH_PREDICTOR_BTB_EN`, two taken updates at 0x40 with target 0x80 make lookup 0x40 give `pred_hit=1`, `pred_taken=1`, `pred_target=0x80`.
- **Same-cycle update and lookup:** an update and lookup at the same index in one cycle return the old value; the next cycle returns the new value.
- **Stats and reset priority:**
  - With STAT_W=4, 20 mispredicted updates leave both stats saturated at 15.
  - Asserting `reset` with `update_valid=1` leaves the table at initial values and the stats at 0.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared helpers and default constants for the branch predictor slice.
//   - BP_* localparams : default parameter values for branch_predictor
//   - bp_idx           : PC shifted down past the byte offset; callers keep the
//                        low IDX_W bits (the table index) by truncating cast
//   - ctr_init         : weakly-not-taken reset value for a direction counter
//   - sat_max          : all-ones value of a given width, zero-extended to 64
//   - sat_inc/sat_dec  : saturating step on a zero-extended value
// All helpers work on 64-bit zero-extended values so one definition serves
// every counter width up to 64 bits.
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int BP_ENTRIES = 64;
  localparam int BP_CTR_W   = 2;
  localparam int BP_PC_W    = 64;
  localparam int BP_STAT_W  = 32;

  // Bits [1:0] of a PC never select an entry; the caller truncates the result
  // to IDX_W bits, which leaves pc[IDX_W+1:2].
  function automatic logic [63:0] bp_idx(input logic [63:0] pc);
    return pc >> 2;
  endfunction

  // 2^(ctr_w-1) - 1: just below the taken threshold (0 for a 1-bit counter).
  function automatic logic [3:0] ctr_init(input int ctr_w);
    logic [3:0] one;
    one = 4'd1;
    return (one << (ctr_w - 1)) - 4'd1;
  endfunction

  function automatic logic [63:0] sat_max(input int width);
    return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

  function automatic logic [63:0] sat_dec(input logic [63:0] value);
    return (value == 64'd0) ? value : value - 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up/down counter that sticks at 0 and at all-ones instead of wrapping.
// Ports:
//   clk        in  1 : clock, rising edge
//   reset      in  1 : synchronous active-high, clears the count
//   load       in  1 : synchronous load of load_value (below reset priority)
//   load_value in  W : value taken on load
//   inc        in  1 : count up by one (saturating)
//   dec        in  1 : count down by one (saturating)
//   count      out W : current count
// ---------------------------------------------------------------------------
module sat_counter
  import bp_pkg::*;
#(
  parameter int W = BP_STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [63:0] MAX_VALUE = sat_max(W);

  // Reset beats load beats counting; inc and dec together cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && !dec) begin
      count <= W'(sat_inc(64'(count), MAX_VALUE));
    end else if (dec && !inc) begin
      count <= W'(sat_dec(64'(count)));
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Dynamic branch predictor: a table of saturating direction counters indexed
// by pc[IDX_W+1:2], an optional branch target buffer, and saturating
// performance counters. Lookup is combinational; training takes effect on the
// cycle after the edge that samples it (read-before-write on a same-index
// lookup). Assumes PC_W <= 64.
// Optional feature: define BRANCH_PREDICTOR_BTB_EN to add per-entry valid,
// tag and target storage.
// Ports:
//   clk               in  1      : clock, rising edge
//   reset             in  1      : synchronous active-high
//   lookup_pc         in  PC_W   : PC being fetched
//   pred_taken        out 1      : predicted taken
//   pred_hit          out 1      : BTB tag match (0 without BTB)
//   pred_target       out PC_W   : predicted next PC
//   update_valid      in  1      : resolved branch present this cycle
//   update_pc         in  PC_W   : PC of the resolved branch
//   update_taken      in  1      : actual outcome
//   update_target     in  PC_W   : actual taken target
//   update_mispredict in  1      : pipeline flushed for this branch
//   stat_branches     out STAT_W : resolved branch count (saturating)
//   stat_mispredicts  out STAT_W : mispredicted branch count (saturating)
// ---------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int CTR_W   = BP_CTR_W,
  parameter int PC_W    = BP_PC_W,
  parameter int STAT_W  = BP_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [PC_W-1:0]   pred_target,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic [PC_W-1:0]   update_target,
  input  logic              update_mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int               IDX_W    = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [63:0]      CTR_MAX  = sat_max(CTR_W);

  // Register array rather than RAM: the read is combinational and reset must
  // restore every entry in a single cycle.
  logic [CTR_W-1:0] ctr [ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic             lookup_msb;
  logic [PC_W-1:0]  fall_through;
  logic [CTR_W-1:0] update_old;
  logic [CTR_W-1:0] update_new;

  assign lookup_idx   = IDX_W'(bp_idx(64'(lookup_pc)));
  assign update_idx   = IDX_W'(bp_idx(64'(update_pc)));
  assign lookup_msb   = ctr[lookup_idx][CTR_W-1];
  assign fall_through = lookup_pc + PC_W'(4);

  // Next value for the trained entry, using the same saturating helpers as
  // the stats counters.
  assign update_old = ctr[update_idx];
  assign update_new = update_taken ? CTR_W'(sat_inc(64'(update_old), CTR_MAX))
                                   : CTR_W'(sat_dec(64'(update_old)));

  // Direction table: reset to weakly-not-taken, otherwise train one entry per
  // resolved branch. No tag check, so aliasing PCs share a counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      ctr[update_idx] <= update_new;
    end
  end

`ifdef BRANCH_PREDICTOR_BTB_EN
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [PC_W-1:0]  btb_target [ENTRIES];

  logic [TAG_W-1:0] lookup_tag;
  logic [TAG_W-1:0] update_tag;

  assign lookup_tag = TAG_W'(64'(lookup_pc) >> (IDX_W + 2));
  assign update_tag = TAG_W'(64'(update_pc) >> (IDX_W + 2));

  // Only the valid bits need clearing on reset; a taken branch claims its
  // entry outright, evicting whatever aliased there before.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (update_valid && update_taken) begin
      btb_valid[update_idx] <= 1'b1;
    end
  end

  // Tag and target payload, written alongside the valid bit; reset still
  // suppresses the write so an update during reset leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset && update_valid && update_taken) begin
      btb_tag[update_idx]    <= update_tag;
      btb_target[update_idx] <= update_target;
    end
  end

  assign pred_hit    = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
  assign pred_taken  = pred_hit && lookup_msb;
  assign pred_target = pred_taken ? btb_target[lookup_idx] : fall_through;
`else
  // Without a BTB the target comes from decode; only the direction is given.
  logic unused_update_target;

  assign unused_update_target = ^update_target;
  assign pred_hit             = 1'b0;
  assign pred_taken           = lookup_msb;
  assign pred_target          = fall_through;
`endif

  // Performance counters: never wrap, cleared by reset.
  sat_counter #(.W(STAT_W)) u_stat_branches (
    .clk        (clk),
    .reset      (reset),
    .load       (1'b0),
    .load_value ('0),
    .inc        (update_valid),
    .dec        (1'b0),
    .count      (stat_branches)
  );

  sat_counter #(.W(STAT_W)) u_stat_mispredicts (
    .clk        (clk),
    .reset      (reset),
    .load       (1'b0),
    .load_value ('0),
    .inc        (update_valid && update_mispredict),
    .dec        (1'b0),
    .count      (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor (ENTRIES=64, CTR_W=2, PC_W=64,
// STAT_W=4). Expected outputs come from a behavioural model of the table,
// BTB and stats; the model adapts when BRANCH_PREDICTOR_BTB_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int PC_W   = 64;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_taken;
  logic              pred_hit;
  logic [PC_W-1:0]   pred_target;
  logic              update_valid;
  logic [PC_W-1:0]   update_pc;
  logic              update_taken;
  logic [PC_W-1:0]   update_target;
  logic              update_mispredict;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  typedef struct {
    string       name;
    logic        taken;
    logic        hit;
    logic [63:0] target;
    logic [3:0]  branches;
    logic [3:0]  mispredicts;
  } expect_t;

  expect_t scoreboard[$];

  int          m_ctr    [64];
  bit          m_valid  [64];
  logic [55:0] m_tag    [64];
  logic [63:0] m_target [64];
  int          m_branches;
  int          m_mispredicts;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES (64),
    .CTR_W   (2),
    .PC_W    (PC_W),
    .STAT_W  (STAT_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .lookup_pc         (lookup_pc),
    .pred_taken        (pred_taken),
    .pred_hit          (pred_hit),
    .pred_target       (pred_target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model reset: weakly-not-taken counters, empty BTB, zero stats.
  function automatic void modelReset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]    = 1;
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
    end
    m_branches    = 0;
    m_mispredicts = 0;
  endfunction

  // Expected combinational outputs given the model state before the edge.
  function automatic expect_t modelPredict(input string name, input logic [63:0] pc);
    expect_t e;
    int      idx;
    bit      dir;
    idx = int'(pc[7:2]);
    dir = (m_ctr[idx] >= 2);
    e.name = name;
`ifdef BRANCH_PREDICTOR_BTB_EN
    e.hit    = m_valid[idx] && (m_tag[idx] == pc[63:8]);
    e.taken  = e.hit && dir;
    e.target = e.taken ? m_target[idx] : pc + 64'd4;
`else
    e.hit    = 1'b0;
    e.taken  = dir;
    e.target = pc + 64'd4;
`endif
    e.branches    = 4'(m_branches);
    e.mispredicts = 4'(m_mispredicts);
    return e;
  endfunction

  // Model state change at the clock edge; reset drops any concurrent update.
  function automatic void modelUpdate(input logic rst, input logic uv,
                                      input logic [63:0] upc, input logic ut,
                                      input logic [63:0] utgt, input logic ump);
    int idx;
    if (rst) begin
      modelReset();
    end else if (uv) begin
      idx = int'(upc[7:2]);
      if (ut) begin
        if (m_ctr[idx] < 3) m_ctr[idx]++;
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = upc[63:8];
        m_target[idx] = utgt;
      end else begin
        if (m_ctr[idx] > 0) m_ctr[idx]--;
      end
      if (m_branches < 15) m_branches++;
      if (ump && m_mispredicts < 15) m_mispredicts++;
    end
  endfunction

  // One cycle: drive inputs after the falling edge, queue the expectation,
  // compare once the combinational outputs settle, then advance the model.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [63:0] lpc, input logic uv,
                               input logic [63:0] upc, input logic ut,
                               input logic [63:0] utgt, input logic ump);
    expect_t e;
    @(negedge clk);
    reset             = rst;
    lookup_pc         = lpc;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_mispredict = ump;
    scoreboard.push_back(modelPredict(name, lpc));
    #1;
    e = scoreboard.pop_front();
    checkOutput({e.name, ".taken"},  64'(pred_taken),       64'(e.taken));
    checkOutput({e.name, ".hit"},    64'(pred_hit),         64'(e.hit));
    checkOutput({e.name, ".target"}, pred_target,           e.target);
    checkOutput({e.name, ".br"},     64'(stat_branches),    64'(e.branches));
    checkOutput({e.name, ".mp"},     64'(stat_mispredicts), 64'(e.mispredicts));
    modelUpdate(rst, uv, upc, ut, utgt, ump);
  endtask

  initial begin
    logic [63:0] rpc;
    logic [63:0] rupc;

    $display("[TB] starting branch_predictor bench");
    reset             = 1'b1;
    lookup_pc         = 64'h100;
    update_valid      = 1'b0;
    update_pc         = '0;
    update_taken      = 1'b0;
    update_target     = '0;
    update_mispredict = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);

    // Reset state
    applyStimulus("reset_state", 1'b0, 64'h100, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);

    // Direction training at 0x100, including saturation at 3
    applyStimulus("train_t1",    1'b0, 64'h100, 1'b1, 64'h100, 1'b1, 64'h180, 1'b1);
    applyStimulus("train_t2",    1'b0, 64'h100, 1'b1, 64'h100, 1'b1, 64'h180, 1'b0);
    applyStimulus("train_t3",    1'b0, 64'h100, 1'b1, 64'h100, 1'b1, 64'h180, 1'b0);
    applyStimulus("train_chk",   1'b0, 64'h100, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0);
    applyStimulus("train_nt1",   1'b0, 64'h100, 1'b1, 64'h100, 1'b0, 64'h0,   1'b1);
    applyStimulus("train_nt2",   1'b0, 64'h100, 1'b1, 64'h100, 1'b0, 64'h0,   1'b0);
    applyStimulus("train_nt_chk",1'b0, 64'h100, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0);

    // Same index looked up and updated in one cycle: old value, then new
    applyStimulus("same_old",    1'b0, 64'h100, 1'b1, 64'h100, 1'b1, 64'h180, 1'b0);
    applyStimulus("same_new",    1'b0, 64'h100, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0);

    // Aliasing: 0x200 shares index 0 with 0x100 but not its tag
    applyStimulus("alias_t1",    1'b0, 64'h300, 1'b1, 64'h200, 1'b1, 64'h240, 1'b0);
    applyStimulus("alias_t2",    1'b0, 64'h300, 1'b1, 64'h200, 1'b1, 64'h240, 1'b0);
    applyStimulus("alias_chk",   1'b0, 64'h100, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0);

    // BTB target at 0x40 -> 0x80
    applyStimulus("btb_t1",      1'b0, 64'h40,  1'b1, 64'h40,  1'b1, 64'h80,  1'b1);
    applyStimulus("btb_t2",      1'b0, 64'h44,  1'b1, 64'h40,  1'b1, 64'h80,  1'b0);
    applyStimulus("btb_chk",     1'b0, 64'h40,  1'b0, 64'h0,   1'b0, 64'h0,   1'b0);

    // Fall-through wraps modulo 2^64
    applyStimulus("wrap",        1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);

    // Stats saturate at 15 with STAT_W=4
    for (int i = 0; i < 20; i++) begin
      rupc = 64'($urandom_range(0, 255)) << 2;
      applyStimulus("stat_sat", 1'b0, 64'h500, 1'b1, rupc, 1'($urandom_range(0, 1)),
                    64'($urandom) << 2, 1'b1);
    end
    applyStimulus("stat_chk",    1'b0, 64'h40,  1'b0, 64'h0,   1'b0, 64'h0,   1'b0);

    // Make sure 0x100 and 0x40 are strongly trained before the reset check
    applyStimulus("pre_rst_t1",  1'b0, 64'h40,  1'b1, 64'h100, 1'b1, 64'h180, 1'b0);
    applyStimulus("pre_rst_t2",  1'b0, 64'h100, 1'b1, 64'h100, 1'b1, 64'h180, 1'b0);
    applyStimulus("pre_rst_t3",  1'b0, 64'h100, 1'b1, 64'h40,  1'b1, 64'h80,  1'b0);
    applyStimulus("pre_rst_t4",  1'b0, 64'h40,  1'b1, 64'h40,  1'b1, 64'h80,  1'b0);

    // Reset wins over a concurrent update
    applyStimulus("rst_upd",     1'b1, 64'h100, 1'b1, 64'h100, 1'b1, 64'h180, 1'b1);
    applyStimulus("after_rst",   1'b0, 64'h100, 1'b0, 64'h0,   1'b0, 64'h0,   1'b0);
    applyStimulus("after_rst2",  1'b0, 64'h40,  1'b0, 64'h0,   1'b0, 64'h0,   1'b0);

    // Random mix over a small PC pool so entries alias and hit often
    for (int i = 0; i < 80; i++) begin
      rpc  = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 15)) << 2);
      rupc = (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 15)) << 2);
      applyStimulus("random", 1'($urandom_range(0, 29) == 0), rpc,
                    1'($urandom_range(0, 1)), rupc, 1'($urandom_range(0, 1)),
                    64'($urandom) << 2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
